// File: rtl/ultrasonic_ranger_if.sv
// Signal bundle between the ultrasonic ranger and its surroundings
// (sensor pins plus the decision outputs feeding the PWM driver).
//   ECHO        sensor echo, asynchronous, driven by the sensor side
//   TRIG        sensor trigger pulse
//   DRIVER      2-bit command: 00 stop, 01 forward, 10 left, 11 right
//   ECHO_TICKS  last completed echo width in 10 us ticks
//   VALID       one-cycle pulse per completed measurement
//   FAULT       last measurement saw no echo
// master = the ranger, slave = sensor / consumer side.
`timescale 1ns/1ps
interface ultrasonic_ranger_if;
    logic        ECHO;
    logic        TRIG;
    logic [1:0]  DRIVER;
    logic [11:0] ECHO_TICKS;
    logic        VALID;
    logic        FAULT;

    modport master (
        input  ECHO,
        output TRIG, DRIVER, ECHO_TICKS, VALID, FAULT
    );

    modport slave (
        output ECHO,
        input  TRIG, DRIVER, ECHO_TICKS, VALID, FAULT
    );
endinterface

// File: rtl/ultrasonic_ranger.sv
// Front ultrasonic ranger: fires the sensor trigger every PERIOD ticks,
// measures the echo width in ticks, classifies the distance (near / mid /
// far) and, once CONFIRM identical classifications arrive in a row, drives
// the command for the PWM driver. Obstacle episodes alternate turning
// left and right.
// Ports:
//   CLK  10 us tick clock
//   RST  synchronous reset, active-high
//   bus  ultrasonic_ranger_if.master (ECHO in; TRIG, DRIVER, ECHO_TICKS,
//        VALID, FAULT out)
`timescale 1ns/1ps
module ultrasonic_ranger #(
    parameter int PERIOD       = 6000,
    parameter int TRIG_LEN     = 2,
    parameter int RISE_TIMEOUT = 3000,
    parameter int ECHO_MAX     = 2320,
    parameter int STOP_TICKS   = 116,
    parameter int TURN_TICKS   = 290,
    parameter int CONFIRM      = 2
) (
    input  logic                CLK,
    input  logic                RST,
    ultrasonic_ranger_if.master bus
);

    localparam int CW = $clog2(CONFIRM + 1);

    localparam logic [12:0]   PERIOD_SAT  = 13'(PERIOD);
    localparam logic [12:0]   PERIOD_LAST = 13'(PERIOD - 1);
    localparam logic [11:0]   TRIG_LEN_T  = 12'(TRIG_LEN);
    localparam logic [11:0]   RISE_LAST   = 12'(RISE_TIMEOUT - 1);
    localparam logic [11:0]   ECHO_LAST   = 12'(ECHO_MAX - 1);
    localparam logic [11:0]   ECHO_SAT    = 12'(ECHO_MAX);
    localparam logic [11:0]   STOP_T      = 12'(STOP_TICKS);
    localparam logic [11:0]   TURN_T      = 12'(TURN_TICKS);
    localparam logic [CW-1:0] CONFIRM_N   = CW'(CONFIRM);

    localparam logic [1:0] DRV_STOP  = 2'b00;
    localparam logic [1:0] DRV_FWD   = 2'b01;
    localparam logic [1:0] DRV_LEFT  = 2'b10;
    localparam logic [1:0] DRV_RIGHT = 2'b11;

    typedef enum logic [2:0] {
        ST_TRIG, ST_WAIT_RISE, ST_MEASURE, ST_DECIDE, ST_WAIT_PERIOD
    } state_t;

    typedef enum logic [1:0] {CLS_NEAR, CLS_MID, CLS_FAR} cls_t;

    function automatic cls_t classify(input logic fault, input logic [11:0] ticks);
        if (fault || ticks < STOP_T) return CLS_NEAR;
        if (ticks < TURN_T)          return CLS_MID;
        return CLS_FAR;
    endfunction

    // Saturating run-length of identical classifications.
    function automatic logic [CW-1:0] confirm_next(input logic same, input logic [CW-1:0] cur);
        if (!same)             return CW'(1);
        if (cur >= CONFIRM_N)  return CONFIRM_N;
        return cur + CW'(1);
    endfunction

    // dir = 0 means the next obstacle episode turns left.
    function automatic logic [1:0] command(input cls_t cls, input logic dir);
        case (cls)
            CLS_FAR: return DRV_FWD;
            CLS_MID: return dir ? DRV_RIGHT : DRV_LEFT;
            default: return DRV_STOP;
        endcase
    endfunction

    state_t        state_q, state_d;
    logic [12:0]   period_q, period_d;
    logic [11:0]   tick_q, tick_d;       // trigger length, rise timeout or echo width, by state
    logic          echo_p0, echo_p1, echo_p2;
    logic          trig_q, trig_d;
    logic          valid_q, valid_d;
    logic          fault_q, fault_d;
    logic [1:0]    driver_q, driver_d;
    logic [11:0]   ticks_q, ticks_d;
    logic [CW-1:0] confirm_q, confirm_d;
    cls_t          prev_cls_q, prev_cls_d;
    logic          dir_q, dir_d;

    logic          done;
    logic          res_fault;
    logic [11:0]   res_ticks;
    cls_t          cls;
    logic [1:0]    code;
    logic          rise;

    // echo_p1 is the synchronized echo; echo_p2 is its previous value.
    assign rise = echo_p1 & ~echo_p2;

    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        period_d   = (period_q >= PERIOD_SAT) ? PERIOD_SAT : period_q + 13'd1;
        trig_d     = 1'b0;
        valid_d    = 1'b0;
        fault_d    = fault_q;
        driver_d   = driver_q;
        ticks_d    = ticks_q;
        confirm_d  = confirm_q;
        prev_cls_d = prev_cls_q;
        dir_d      = dir_q;
        done       = 1'b0;
        res_fault  = 1'b0;
        res_ticks  = '0;
        cls        = CLS_NEAR;
        code       = DRV_STOP;

        case (state_q)
            ST_TRIG: begin
                if (tick_q < TRIG_LEN_T) begin
                    trig_d = 1'b1;
                    tick_d = tick_q + 12'd1;
                end else begin
                    state_d = ST_WAIT_RISE;
                    tick_d  = '0;
                end
            end
            ST_WAIT_RISE: begin
                if (rise) begin
                    // The cycle that reveals the edge is already the first high tick.
                    state_d = ST_MEASURE;
                    tick_d  = 12'd1;
                end else if (tick_q == RISE_LAST) begin
                    done      = 1'b1;
                    res_fault = 1'b1;
                end else begin
                    tick_d = tick_q + 12'd1;
                end
            end
            ST_MEASURE: begin
                if (!echo_p1) begin
                    done      = 1'b1;
                    res_ticks = tick_q;
                end else if (tick_q == ECHO_LAST) begin
                    done      = 1'b1;
                    res_ticks = ECHO_SAT;
                end else begin
                    tick_d = tick_q + 12'd1;
                end
            end
            ST_DECIDE: begin
                state_d = ST_WAIT_PERIOD;
            end
            ST_WAIT_PERIOD: begin
                // Leaving here on the edge the counter reaches PERIOD keeps
                // trigger starts exactly PERIOD ticks apart.
                if (period_q >= PERIOD_LAST) begin
                    state_d  = ST_TRIG;
                    period_d = '0;
                    tick_d   = '0;
                end
            end
            default: state_d = ST_TRIG;
        endcase

        // Results are registered on the edge into DECIDE so VALID, ECHO_TICKS
        // and DRIVER all change together.
        if (done) begin
            state_d    = ST_DECIDE;
            valid_d    = 1'b1;
            fault_d    = res_fault;
            ticks_d    = res_fault ? 12'd0 : res_ticks;
            cls        = classify(res_fault, res_ticks);
            confirm_d  = confirm_next((confirm_q != '0) && (cls == prev_cls_q), confirm_q);
            prev_cls_d = cls;
            if (confirm_d == CONFIRM_N) begin
                code = command(cls, dir_q);
                if (driver_q[1] && !code[1]) dir_d = ~dir_q;
                driver_d = code;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_TRIG;
            period_q   <= '0;
            tick_q     <= '0;
            echo_p0    <= 1'b0;
            echo_p1    <= 1'b0;
            echo_p2    <= 1'b0;
            trig_q     <= 1'b0;
            valid_q    <= 1'b0;
            fault_q    <= 1'b0;
            driver_q   <= DRV_STOP;
            ticks_q    <= '0;
            confirm_q  <= '0;
            prev_cls_q <= CLS_NEAR;
            dir_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            period_q   <= period_d;
            tick_q     <= tick_d;
            echo_p0    <= bus.ECHO;
            echo_p1    <= echo_p0;
            echo_p2    <= echo_p1;
            trig_q     <= trig_d;
            valid_q    <= valid_d;
            fault_q    <= fault_d;
            driver_q   <= driver_d;
            ticks_q    <= ticks_d;
            confirm_q  <= confirm_d;
            prev_cls_q <= prev_cls_d;
            dir_q      <= dir_d;
        end
    end

    assign bus.TRIG       = trig_q;
    assign bus.VALID      = valid_q;
    assign bus.FAULT      = fault_q;
    assign bus.DRIVER     = driver_q;
    assign bus.ECHO_TICKS = ticks_q;

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Bench for ultrasonic_ranger. A time-scaled instance (shorter period and
// timeouts, same thresholds) runs directed and random echo scenarios
// against a behavioural model of the distance/command rules; a second
// instance with default parameters checks the real timing with ECHO idle.
`timescale 1ns/1ps
module tb_ultrasonic_ranger;
    localparam int P_PERIOD = 800;
    localparam int P_TRIG   = 2;
    localparam int P_RISE   = 500;
    localparam int P_MAX    = 400;
    localparam int P_STOP   = 116;
    localparam int P_TURN   = 290;
    localparam int P_CONF   = 2;

    localparam int K_ECHO  = 0;
    localparam int K_NONE  = 1;
    localparam int K_STUCK = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_d = 1'b1;
    always #5 clk = ~clk;

    ultrasonic_ranger_if bus ();
    ultrasonic_ranger_if bus_d ();

    ultrasonic_ranger #(
        .PERIOD(P_PERIOD), .TRIG_LEN(P_TRIG), .RISE_TIMEOUT(P_RISE),
        .ECHO_MAX(P_MAX), .STOP_TICKS(P_STOP), .TURN_TICKS(P_TURN), .CONFIRM(P_CONF)
    ) dut (
        .CLK(clk), .RST(rst), .bus(bus.master)
    );

    ultrasonic_ranger dut_def (
        .CLK(clk), .RST(rst_d), .bus(bus_d.master)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected measurement results, written by the stimulus, consumed by the compare process.
    int exp_ticks [0:63];
    int exp_fault [0:63];
    int wr = 0;
    int rd = 0;

    // Model and tracking state owned by the compare process.
    int cyc = 0, last_rise = -1, trig_hi = 0, valid_cnt = 0;
    int prev_trig = 0, prev_valid = 0, prev_rst = 0;
    int mdrv = 0, mdir = 0;
    int hist[$];
    int e_t, e_f, cls_m, nd;
    bit all_same;

    always begin
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            check("reset_trig", bus.TRIG, 0);
            check("reset_driver", bus.DRIVER, 0);
            check("reset_ticks", bus.ECHO_TICKS, 0);
            check("reset_valid", bus.VALID, 0);
            check("reset_fault", bus.FAULT, 0);
            rd = wr;
            hist.delete();
            mdrv = 0; mdir = 0; last_rise = -1; trig_hi = 0;
            prev_trig = 0; prev_valid = 0;
        end else begin
            if (prev_rst != 0) check("trig_after_release", bus.TRIG, 1);
            if (bus.TRIG && prev_trig == 0) begin
                if (last_rise >= 0) check("trig_period", cyc - last_rise, P_PERIOD);
                last_rise = cyc;
                trig_hi = 0;
            end
            if (bus.TRIG) trig_hi++;
            if (!bus.TRIG && prev_trig != 0) check("trig_width", trig_hi, P_TRIG);
            if (bus.VALID) begin
                valid_cnt++;
                check("valid_single_cycle", prev_valid, 0);
                check("valid_expected", (rd != wr) ? 1 : 0, 1);
                if (rd != wr) begin
                    e_t = exp_ticks[rd % 64];
                    e_f = exp_fault[rd % 64];
                    rd++;
                    cls_m = (e_f != 0) ? 0 : (e_t < P_STOP) ? 0 : (e_t < P_TURN) ? 1 : 2;
                    hist.push_back(cls_m);
                    if (hist.size() > 8) void'(hist.pop_front());
                    all_same = (hist.size() >= P_CONF);
                    for (int k = 1; k < P_CONF && all_same; k++)
                        if (hist[hist.size() - 1 - k] != cls_m) all_same = 1'b0;
                    if (all_same) begin
                        nd = (cls_m == 0) ? 0 : (cls_m == 2) ? 1 : (mdir != 0 ? 3 : 2);
                        if (mdrv >= 2 && nd < 2) mdir = 1 - mdir;
                        mdrv = nd;
                    end
                    check("echo_ticks", bus.ECHO_TICKS, (e_f != 0) ? 0 : e_t);
                    check("fault", bus.FAULT, e_f);
                    if (e_f != 0) check("fault_latency", cyc - last_rise, P_RISE + 2);
                end
            end
            check("driver", bus.DRIVER, mdrv);
            prev_trig = bus.TRIG;
            prev_valid = bus.VALID;
        end
        prev_rst = rst;
    end

    task automatic wait_trig(output bit got);
        got = 1'b0;
        for (int i = 0; i < 3 * P_PERIOD; i++) begin
            @(negedge clk);
            if (bus.TRIG) begin
                got = 1'b1;
                break;
            end
        end
        check("trig_seen", got, 1);
    endtask

    task automatic do_period(input int kind, input int width);
        int base, d;
        bit got;
        base = valid_cnt;
        if (kind == K_STUCK) bus.ECHO = 1'b1;
        wait_trig(got);
        if (got) begin
            exp_ticks[wr % 64] = (kind == K_ECHO) ? ((width > P_MAX) ? P_MAX : width) : 0;
            exp_fault[wr % 64] = (kind == K_ECHO) ? 0 : 1;
            wr++;
            if (kind == K_ECHO) begin
                d = $urandom_range(2, 30);
                repeat (d) @(negedge clk);
                bus.ECHO = 1'b1;
                repeat (width) @(negedge clk);
                bus.ECHO = 1'b0;
            end
            for (int i = 0; i < 2 * P_PERIOD && valid_cnt == base; i++) @(negedge clk);
            check("valid_seen", (valid_cnt > base) ? 1 : 0, 1);
        end
        bus.ECHO = 1'b0;
    endtask

    task automatic pair(input int width, input int drv);
        do_period(K_ECHO, width);
        do_period(K_ECHO, width);
        check("pair_driver", bus.DRIVER, drv);
    endtask

    // Default-parameter instance: real 6000-tick period and 3000-tick rise timeout.
    bit def_done = 1'b0;
    initial begin
        int rises[$], vcyc[$], vf[$], vt[$], vd[$];
        int pt;
        pt = 0;
        bus_d.ECHO = 1'b0;
        repeat (3) @(negedge clk);
        rst_d = 1'b0;
        for (int n = 1; n <= 12100; n++) begin
            @(posedge clk);
            #1;
            if (bus_d.TRIG && pt == 0) rises.push_back(n);
            pt = bus_d.TRIG;
            if (bus_d.VALID) begin
                vcyc.push_back(n);
                vf.push_back(bus_d.FAULT);
                vt.push_back(bus_d.ECHO_TICKS);
                vd.push_back(bus_d.DRIVER);
            end
        end
        check("def_trig_count", (rises.size() >= 2) ? 1 : 0, 1);
        check("def_valid_count", (vcyc.size() >= 2) ? 1 : 0, 1);
        if (rises.size() >= 2 && vcyc.size() >= 2) begin
            check("def_first_trig", rises[0], 1);
            check("def_period", rises[1] - rises[0], 6000);
            check("def_fault_latency", vcyc[0] - rises[0], 3002);
            check("def_fault", vf[0], 1);
            check("def_ticks", vt[0], 0);
            check("def_driver", vd[1], 0);
        end
        def_done = 1'b1;
    end

    initial begin
        bit got;
        int b, reps;
        bus.ECHO = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // ECHO idle: two faults, command stays stop.
        do_period(K_NONE, 0);
        check("idle_fault", bus.FAULT, 1);
        check("idle_ticks", bus.ECHO_TICKS, 0);
        check("idle_driver1", bus.DRIVER, 0);
        do_period(K_NONE, 0);
        check("idle_driver2", bus.DRIVER, 0);

        // Far twice: stop until confirmed, then forward.
        do_period(K_ECHO, 350);
        check("far1_driver", bus.DRIVER, 0);
        check("far1_ticks", bus.ECHO_TICKS, 350);
        do_period(K_ECHO, 350);
        check("far2_driver", bus.DRIVER, 1);

        // Turn direction alternates between obstacle episodes.
        pair(200, 2);
        pair(350, 1);
        pair(200, 3);
        pair(350, 1);

        // Near confirmed stops; isolated near readings never do.
        pair(50, 0);
        check("near_fault", bus.FAULT, 0);
        check("near_ticks", bus.ECHO_TICKS, 50);
        pair(350, 1);
        for (int i = 0; i < 2; i++) begin
            do_period(K_ECHO, 50);
            check("single_near_driver", bus.DRIVER, 1);
            do_period(K_ECHO, 350);
            check("single_far_driver", bus.DRIVER, 1);
        end

        // No echo twice, then echo stuck high twice: both faults stop.
        do_period(K_NONE, 0);
        do_period(K_NONE, 0);
        check("fault2_driver", bus.DRIVER, 0);
        pair(350, 1);
        do_period(K_STUCK, 0);
        do_period(K_STUCK, 0);
        check("stuck_driver", bus.DRIVER, 0);
        check("stuck_fault", bus.FAULT, 1);
        check("stuck_ticks", bus.ECHO_TICKS, 0);

        // Long echo saturates at ECHO_MAX and counts as far.
        do_period(K_ECHO, 450);
        check("sat_ticks", bus.ECHO_TICKS, P_MAX);
        check("sat_fault", bus.FAULT, 0);
        do_period(K_ECHO, 450);
        check("sat_driver", bus.DRIVER, 1);

        // Threshold boundaries.
        do_period(K_ECHO, P_STOP - 1);
        pair(P_STOP, 2);
        pair(P_TURN, 1);
        pair(P_TURN - 1, 3);
        pair(50, 0);

        // Randomized runs of classes.
        for (int r = 0; r < 6; r++) begin
            b = $urandom_range(0, 3);
            reps = $urandom_range(1, 2);
            for (int k = 0; k < reps; k++) begin
                case (b)
                    0: do_period(K_ECHO, $urandom_range(1, P_STOP - 1));
                    1: do_period(K_ECHO, $urandom_range(P_STOP, P_TURN - 1));
                    2: do_period(K_ECHO, $urandom_range(P_TURN, 450));
                    default: do_period(K_NONE, 0);
                endcase
            end
        end

        // Reset in the middle of an echo measurement.
        pair(350, 1);
        wait_trig(got);
        repeat (4) @(negedge clk);
        bus.ECHO = 1'b1;
        repeat (100) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_ticks", bus.ECHO_TICKS, 0);
        check("midrst_driver", bus.DRIVER, 0);
        check("midrst_trig", bus.TRIG, 0);
        rst = 1'b0;
        bus.ECHO = 1'b0;
        do_period(K_ECHO, 350);
        check("post_rst_ticks", bus.ECHO_TICKS, 350);
        check("post_rst_driver", bus.DRIVER, 0);

        wait (def_done);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
